axi_master_arb: RTL and testbench

Parametrised AXI4 master port shared by the IFU and LSU, the successor to the fixed fetch/load/store sequencer. It arbitrates one outstanding single-beat transaction at a time between an instruction-fetch request port and a load/store request port. It drives the `io_master_*` AXI channels with configurable data width and IDs. Every request is answered with a registered response pulse that carries data and an error flag.

---
 rtl/axi_master_arb.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_master_arb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arb.sv
// ----------------------------------------------------------------------------
// axi_master_arb
//   Shared AXI4 master port for the IFU and LSU. Only one single-beat
//   transaction is outstanding at a time. The LSU has fixed priority over the
//   IFU. Each accepted request is answered with a one-cycle registered
//   response pulse that carries data and an error flag.
//
// Ports
//   clock, reset        : single rising-edge clock, synchronous active-high reset
//   ifu_req_* / ifu_rsp_* : fetch request (valid/ready/addr) and response pulse
//   lsu_req_* / lsu_*   : load/store request (valid/ready/wen/addr/size/wdata/wstrb)
//   lsu_rsp_*           : load/store response pulse (rdata is 0 for stores)
//   io_master_aw/w/b/ar/r* : AXI4 master channels (len 0, INCR, id per requester)
// ----------------------------------------------------------------------------
module axi_master_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [3:0]  IFU_ID = 4'd0,
    parameter logic [3:0]  LSU_ID = 4'd1,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    // Fetch port
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,
    output logic              ifu_rsp_err,
    // Load/store port
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [2:0]        lsu_size,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_rdata,
    output logic              lsu_rsp_err,
    // AXI write address
    input  logic              io_master_awready,
    output logic              io_master_awvalid,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [3:0]        io_master_awid,
    output logic [7:0]        io_master_awlen,
    output logic [2:0]        io_master_awsize,
    output logic [1:0]        io_master_awburst,
    // AXI write data
    input  logic              io_master_wready,
    output logic              io_master_wvalid,
    output logic [DATA_W-1:0] io_master_wdata,
    output logic [STRB_W-1:0] io_master_wstrb,
    output logic              io_master_wlast,
    // AXI write response
    output logic              io_master_bready,
    input  logic              io_master_bvalid,
    input  logic [1:0]        io_master_bresp,
    input  logic [3:0]        io_master_bid,
    // AXI read address
    input  logic              io_master_arready,
    output logic              io_master_arvalid,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    // AXI read data
    output logic              io_master_rready,
    input  logic              io_master_rvalid,
    input  logic [1:0]        io_master_rresp,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic              io_master_rlast,
    input  logic [3:0]        io_master_rid
);

    localparam logic [2:0] FETCH_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        StIdle,
        StRdAr,
        StRdR,
        StWrReq,
        StWrB
    } state_e;

    state_e r_state, w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_owner;     // 1: LSU owns the transaction, 0: IFU
    logic              r_aw_done;
    logic              r_w_done;

    logic              r_ifu_rsp_valid;
    logic [DATA_W-1:0] r_ifu_rsp_data;
    logic              r_ifu_rsp_err;
    logic              r_lsu_rsp_valid;
    logic [DATA_W-1:0] r_lsu_rsp_rdata;
    logic              r_lsu_rsp_err;

    logic              w_lsu_acc;
    logic              w_ifu_acc;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_r_fire;
    logic              w_b_fire;
    logic [3:0]        w_owner_id;
    logic              w_r_err;
    logic              w_b_err;
    logic              w_unused;

    // Readies are gated by reset so nothing is granted while reset is held.
    assign lsu_req_ready = (r_state == StIdle) & ~reset;
    assign ifu_req_ready = (r_state == StIdle) & ~reset & ~lsu_req_valid;
    assign w_lsu_acc     = lsu_req_ready & lsu_req_valid;
    assign w_ifu_acc     = ifu_req_ready & ifu_req_valid;

    // Handshakes derived from state and done flags rather than the valid outputs.
    assign w_aw_hs  = (r_state == StWrReq) & ~r_aw_done & io_master_awready;
    assign w_w_hs   = (r_state == StWrReq) & ~r_w_done & io_master_wready;
    assign w_r_fire = (r_state == StRdR) & io_master_rvalid;
    assign w_b_fire = (r_state == StWrB) & io_master_bvalid;

    assign w_owner_id = r_owner ? LSU_ID : IFU_ID;
    assign w_r_err    = io_master_rresp[1] | (io_master_rid != w_owner_id) | ~io_master_rlast;
    assign w_b_err    = io_master_bresp[1] | (io_master_bid != LSU_ID);

    // Only the SLVERR/DECERR bit of the response codes matters.
    assign w_unused = ^{io_master_rresp[0], io_master_bresp[0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_lsu_acc) begin
                    w_state_next = lsu_wen ? StWrReq : StRdAr;
                end else if (w_ifu_acc) begin
                    w_state_next = StRdAr;
                end
            end
            StRdAr: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) begin
                    w_state_next = StRdR;
                end
            end
            StRdR: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid) begin
                    w_state_next = StIdle;
                end
            end
            StWrReq: begin
                io_master_awvalid = ~r_aw_done;
                io_master_wvalid  = ~r_w_done;
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_next = StWrB;
                end
            end
            StWrB: begin
                io_master_bready = 1'b1;
                if (io_master_bvalid) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr          <= '0;
            r_size          <= '0;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_owner         <= 1'b0;
            r_aw_done       <= 1'b0;
            r_w_done        <= 1'b0;
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rsp_data  <= '0;
            r_ifu_rsp_err   <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_rdata <= '0;
            r_lsu_rsp_err   <= 1'b0;
        end else begin
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;

            if (w_lsu_acc) begin
                r_addr  <= lsu_addr;
                r_size  <= lsu_size;
                r_wdata <= lsu_wdata;
                r_wstrb <= lsu_wstrb;
                r_owner <= 1'b1;
            end else if (w_ifu_acc) begin
                r_addr  <= ifu_addr;
                r_size  <= FETCH_SIZE;
                r_wdata <= '0;
                r_wstrb <= '0;
                r_owner <= 1'b0;
            end

            // Done flags live only for the duration of the write request phase.
            if (r_state == StWrReq) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (w_r_fire) begin
                if (r_owner) begin
                    r_lsu_rsp_valid <= 1'b1;
                    r_lsu_rsp_rdata <= io_master_rdata;
                    r_lsu_rsp_err   <= w_r_err;
                end else begin
                    r_ifu_rsp_valid <= 1'b1;
                    r_ifu_rsp_data  <= io_master_rdata;
                    r_ifu_rsp_err   <= w_r_err;
                end
            end

            if (w_b_fire) begin
                r_lsu_rsp_valid <= 1'b1;
                r_lsu_rsp_rdata <= '0;
                r_lsu_rsp_err   <= w_b_err;
            end
        end
    end

    assign ifu_rsp_valid = r_ifu_rsp_valid;
    assign ifu_rsp_data  = r_ifu_rsp_data;
    assign ifu_rsp_err   = r_ifu_rsp_err;
    assign lsu_rsp_valid = r_lsu_rsp_valid;
    assign lsu_rsp_rdata = r_lsu_rsp_rdata;
    assign lsu_rsp_err   = r_lsu_rsp_err;

    assign io_master_awaddr  = r_addr;
    assign io_master_awid    = w_owner_id;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = r_size;
    assign io_master_awburst = 2'b01;
    assign io_master_wdata   = r_wdata;
    assign io_master_wstrb   = r_wstrb;
    assign io_master_wlast   = io_master_wvalid;
    assign io_master_araddr  = r_addr;
    assign io_master_arid    = w_owner_id;
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = r_size;
    assign io_master_arburst = 2'b01;

endmodule

// File: tb/tb_axi_master_arb.sv
// ----------------------------------------------------------------------------
// tb_axi_master_arb
//   Directed bench for axi_master_arb. A 32-bit instance is driven cycle by
//   cycle with hand-computed expectations; a 64-bit instance sits behind a
//   tiny always-ready read slave to check size encoding and wide read data.
// ----------------------------------------------------------------------------
module tb_axi_master_arb;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // 32-bit instance signals
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_rdata;
    logic [2:0]  lsu_size;
    logic [3:0]  lsu_wstrb;
    logic        awready, awvalid, wready, wvalid, wlast, bready, bvalid;
    logic        arready, arvalid, rready, rvalid, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awid, arid, wstrb, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    axi_master_arb #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awaddr(awaddr),
        .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
        .io_master_awburst(awburst),
        .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wlast(wlast),
        .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bresp(bresp),
        .io_master_bid(bid),
        .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_araddr(araddr),
        .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
        .io_master_arburst(arburst),
        .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rresp(rresp),
        .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid)
    );

    // 64-bit instance signals
    logic        d64_ifu_req_valid, d64_ifu_req_ready, d64_ifu_rsp_valid, d64_ifu_rsp_err;
    logic [31:0] d64_ifu_addr, d64_lsu_addr, d64_awaddr, d64_araddr;
    logic [63:0] d64_ifu_rsp_data, d64_lsu_rsp_rdata, d64_wdata;
    logic        d64_lsu_req_valid, d64_lsu_req_ready, d64_lsu_rsp_valid, d64_lsu_rsp_err;
    logic [2:0]  d64_lsu_size, d64_awsize, d64_arsize;
    logic [7:0]  d64_wstrb, d64_awlen, d64_arlen;
    logic [3:0]  d64_awid, d64_arid;
    logic [1:0]  d64_awburst, d64_arburst;
    logic        d64_awvalid, d64_wvalid, d64_wlast, d64_bready, d64_arvalid, d64_rready;
    logic        s64_rvalid;
    logic [3:0]  s64_rid;
    logic [2:0]  s64_arsize;

    axi_master_arb #(.ADDR_W(32), .DATA_W(64)) u_dut64 (
        .clock(clock), .reset(reset),
        .ifu_req_valid(d64_ifu_req_valid), .ifu_req_ready(d64_ifu_req_ready),
        .ifu_addr(d64_ifu_addr), .ifu_rsp_valid(d64_ifu_rsp_valid),
        .ifu_rsp_data(d64_ifu_rsp_data), .ifu_rsp_err(d64_ifu_rsp_err),
        .lsu_req_valid(d64_lsu_req_valid), .lsu_req_ready(d64_lsu_req_ready), .lsu_wen(1'b0),
        .lsu_addr(d64_lsu_addr), .lsu_size(d64_lsu_size), .lsu_wdata(64'd0), .lsu_wstrb(8'd0),
        .lsu_rsp_valid(d64_lsu_rsp_valid), .lsu_rsp_rdata(d64_lsu_rsp_rdata),
        .lsu_rsp_err(d64_lsu_rsp_err),
        .io_master_awready(1'b0), .io_master_awvalid(d64_awvalid), .io_master_awaddr(d64_awaddr),
        .io_master_awid(d64_awid), .io_master_awlen(d64_awlen), .io_master_awsize(d64_awsize),
        .io_master_awburst(d64_awburst),
        .io_master_wready(1'b0), .io_master_wvalid(d64_wvalid), .io_master_wdata(d64_wdata),
        .io_master_wstrb(d64_wstrb), .io_master_wlast(d64_wlast),
        .io_master_bready(d64_bready), .io_master_bvalid(1'b0), .io_master_bresp(2'b00),
        .io_master_bid(4'd0),
        .io_master_arready(1'b1), .io_master_arvalid(d64_arvalid), .io_master_araddr(d64_araddr),
        .io_master_arid(d64_arid), .io_master_arlen(d64_arlen), .io_master_arsize(d64_arsize),
        .io_master_arburst(d64_arburst),
        .io_master_rready(d64_rready), .io_master_rvalid(s64_rvalid), .io_master_rresp(2'b00),
        .io_master_rdata(64'h0123_4567_89AB_CDEF), .io_master_rlast(1'b1),
        .io_master_rid(s64_rid)
    );

    // Always-ready read slave: answers one cycle after each AR handshake.
    always @(posedge clock) begin
        if (reset) begin
            s64_rvalid <= 1'b0;
            s64_rid    <= 4'd0;
            s64_arsize <= 3'd0;
        end else begin
            s64_rvalid <= d64_arvalid;
            if (d64_arvalid) begin
                s64_rid    <= d64_arid;
                s64_arsize <= d64_arsize;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Completes an AR handshake from RD_AR; returns in the RD_R cycle.
    task automatic ar_accept();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
    endtask

    // Presents one R beat in RD_R; returns in the response cycle.
    task automatic read_beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id,
                             input logic last);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rid    = id;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        #1;
    endtask

    initial begin
        logic got;
        reset = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_size = 0; lsu_wdata = 0; lsu_wstrb = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0; rlast = 0; rid = 0;
        d64_ifu_req_valid = 0; d64_ifu_addr = 0;
        d64_lsu_req_valid = 0; d64_lsu_addr = 0; d64_lsu_size = 0;
        tick();
        tick();

        // Reset state
        check("rst_lsu_ready", lsu_req_ready, 0);
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
        check("rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        check("rst_rsp_data", {ifu_rsp_data, lsu_rsp_rdata}, 0);
        check("rst_rsp_err", {ifu_rsp_err, lsu_rsp_err}, 0);
        reset = 1'b0;
        tick();
        check("idle_ready", {lsu_req_ready, ifu_req_ready}, 2'b11);

        // Stray R beat in IDLE is ignored
        rvalid = 1; rid = 0; rlast = 1; rdata = 32'hAA;
        #1;
        check("stray_r_rready", rready, 0);
        tick();
        rvalid = 0;
        #1;
        check("stray_r_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);

        // Zero-wait fetch of 0x8000_0000
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        check("f_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0;
        #1;
        check("f_arvalid", arvalid, 1);
        check("f_araddr", araddr, 32'h8000_0000);
        check("f_arfields", {arid, arsize, arlen, arburst}, {4'd0, 3'd2, 8'd0, 2'b01});
        ar_accept();
        check("f_rd_r", {arvalid, rready, ifu_rsp_valid}, 3'b010);
        read_beat(32'h0000_0413, 2'b00, 4'd0, 1'b1);
        check("f_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b10);
        check("f_rsp_data", ifu_rsp_data, 32'h0000_0413);
        check("f_rsp_err", ifu_rsp_err, 0);
        check("f_idle_in_rsp", ifu_req_ready, 1);
        tick();
        check("f_pulse_once", ifu_rsp_valid, 0);
        check("f_data_hold", ifu_rsp_data, 32'h0000_0413);

        // LSU priority over simultaneous IFU; IFU then answered with wrong rid
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h1000; lsu_size = 3'd2;
        ifu_req_valid = 1; ifu_addr = 32'h2000;
        #1;
        check("arb_ready", {lsu_req_ready, ifu_req_ready}, 2'b10);
        tick();
        lsu_req_valid = 0;
        #1;
        check("arb_lsu_ar", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h1000});
        check("arb_ifu_wait", ifu_req_ready, 0);
        ar_accept();
        read_beat(32'h1234_5678, 2'b00, 4'd1, 1'b1);
        check("arb_lsu_rsp", {lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_err}, 3'b100);
        check("arb_lsu_data", lsu_rsp_rdata, 32'h1234_5678);
        check("arb_ifu_grant", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0;
        #1;
        check("arb_ifu_ar", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h2000});
        ar_accept();
        read_beat(32'h55, 2'b00, 4'd1, 1'b1);
        check("rid_err", {ifu_rsp_valid, ifu_rsp_err}, 2'b11);
        check("rid_err_data", ifu_rsp_data, 32'h55);

        // Store: AW accepted after 4 cycles of awvalid, W immediately
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h3000; lsu_size = 3'd2;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
        tick();
        lsu_req_valid = 0; wready = 1;
        #1;
        check("st_c1_valids", {awvalid, wvalid, wlast}, 3'b111);
        check("st_w_payload", {wdata, wstrb}, {32'hDEAD_BEEF, 4'b0011});
        check("st_aw_fields", {awaddr, awid, awsize, awlen, awburst},
              {32'h3000, 4'd1, 3'd2, 8'd0, 2'b01});
        tick();
        wready = 0;
        #1;
        check("st_c2_valids", {awvalid, wvalid}, 2'b10);
        tick();
        check("st_c3_valids", {awvalid, wvalid}, 2'b10);
        tick();
        awready = 1;
        #1;
        check("st_c4_valids", {awvalid, wvalid, bready}, 3'b100);
        tick();
        awready = 0;
        #1;
        check("st_wr_b", {awvalid, wvalid, bready, lsu_rsp_valid}, 4'b0010);
        bvalid = 1; bresp = 2'b00; bid = 4'd1;
        tick();
        bvalid = 0;
        #1;
        check("st_rsp", {lsu_rsp_valid, lsu_rsp_err}, 2'b10);
        check("st_rsp_rdata", lsu_rsp_rdata, 0);
        tick();
        check("st_pulse_once", lsu_rsp_valid, 0);

        // Load answered with SLVERR
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h4000; lsu_size = 3'd2;
        tick();
        lsu_req_valid = 0;
        #1;
        ar_accept();
        read_beat(32'h77, 2'b10, 4'd1, 1'b1);
        check("slverr", {lsu_rsp_valid, lsu_rsp_err}, 2'b11);

        // Load missing rlast
        lsu_req_valid = 1;
        tick();
        lsu_req_valid = 0;
        #1;
        ar_accept();
        read_beat(32'h88, 2'b00, 4'd1, 1'b0);
        check("no_rlast_err", {lsu_rsp_valid, lsu_rsp_err}, 2'b11);

        // Reset during WR_B, then a late B beat
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h5000;
        tick();
        lsu_req_valid = 0; awready = 1; wready = 1;
        #1;
        tick();
        awready = 0; wready = 0;
        #1;
        check("rstwb_in_wr_b", bready, 1);
        reset = 1;
        tick();
        check("rstwb_valids", {bready, awvalid, wvalid, arvalid, rready}, 0);
        check("rstwb_readies", {lsu_req_ready, ifu_req_ready}, 0);
        check("rstwb_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_err}, 0);
        check("rstwb_data", {ifu_rsp_data, lsu_rsp_rdata}, 0);
        reset = 0; bvalid = 1; bid = 4'd1;
        tick();
        bvalid = 0;
        #1;
        check("late_b_ignored", {lsu_rsp_valid, bready, lsu_req_ready}, 3'b001);
        tick();
        check("late_b_no_rsp", lsu_rsp_valid, 0);

        // 64-bit build: fetch size and byte load
        d64_ifu_req_valid = 1; d64_ifu_addr = 32'h100;
        tick();
        d64_ifu_req_valid = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (d64_ifu_rsp_valid) got = 1;
        end
        check("w64_fetch_rsp", got, 1);
        check("w64_fetch_arsize", s64_arsize, 3);
        check("w64_fetch_data", d64_ifu_rsp_data, 64'h0123_4567_89AB_CDEF);
        check("w64_fetch_err", d64_ifu_rsp_err, 0);
        d64_lsu_req_valid = 1; d64_lsu_addr = 32'h203; d64_lsu_size = 3'd0;
        tick();
        d64_lsu_req_valid = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (d64_lsu_rsp_valid) got = 1;
        end
        check("w64_byte_rsp", got, 1);
        check("w64_byte_arsize", s64_arsize, 0);
        check("w64_byte_data", d64_lsu_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        check("w64_byte_err", d64_lsu_rsp_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
